// File: rtl/rom_line_reporter.sv
// rom_line_reporter: sends "<addr hex>:<data hex>\r\n" over an 8N1 UART per trigger.
// Ports: clk; reset_n (sync, 1 = reset); address_line, data_line, report_request in;
// tx (serial, idle high), busy, frame_done (1-cycle pulse) out.
// Build option: ROM_LINE_REPORTER_AUTO_TRIGGER_EN adds address-change triggering.
module rom_line_reporter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int CLK_DIVIDER   = 434
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] address_line,
  input  logic [DATA_WIDTH-1:0]    data_line,
  input  logic                     report_request,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int AD    = (ADDRESS_WIDTH + 3) / 4;
  localparam int DD    = (DATA_WIDTH + 3) / 4;
  localparam int NCHAR = AD + DD + 3;
  localparam int BW    = $clog2(CLK_DIVIDER);
  localparam int CW    = $clog2(NCHAR);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIVIDER - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NCHAR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                   state_q, state_d;
  logic [BW-1:0]            baud_q, baud_d;
  logic [2:0]               bit_q, bit_d;
  logic [CW-1:0]            char_q, char_d;
  logic                     pend_q, pend_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                     auto_trig;
  logic                     trig;
  logic                     start;
  logic                     baud_last;
  logic [4*AD-1:0]          apad;
  logic [4*DD-1:0]          dpad;
  logic [7:0]               cur_ch;

  function automatic logic [7:0] hex(input logic [3:0] n);
    hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign baud_last  = (baud_q == BAUD_LAST);

`ifdef ROM_LINE_REPORTER_AUTO_TRIGGER_EN
  logic [ADDRESS_WIDTH-1:0] last_q;

  // Tracks the address of the most recent frame; reset copies the
  // live address so a quiet bus produces no frame after reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      last_q <= address_line;
    end else if (start) begin
      last_q <= address_line;
    end
  end

  assign auto_trig = (address_line != last_q) && !busy && !pend_q;
`else
  assign auto_trig = 1'b0;
`endif

  // A request and an address change in one cycle merge into one trigger.
  assign trig  = report_request | pend_q | auto_trig;
  assign start = (state_q == S_IDLE) && trig;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Frame contents are frozen at start so bus activity mid-frame is ignored.
  always_ff @(posedge clk) begin
    if (start) begin
      addr_q <= address_line;
      data_q <= data_line;
    end
  end

  always_comb begin
    apad = '0;
    dpad = '0;
    apad[ADDRESS_WIDTH-1:0] = addr_q;
    dpad[DATA_WIDTH-1:0]    = data_q;
  end

  // Character at position char_q: address digits, ':', data digits, CR, LF.
  always_comb begin
    cur_ch = 8'h0A;
    for (int i = 0; i < AD; i++) begin
      if (char_q == CW'(i)) begin
        cur_ch = hex(apad[4*(AD-1-i) +: 4]);
      end
    end
    if (char_q == CW'(AD)) begin
      cur_ch = 8'h3A;
    end
    for (int i = 0; i < DD; i++) begin
      if (char_q == CW'(AD + 1 + i)) begin
        cur_ch = hex(dpad[4*(DD-1-i) +: 4]);
      end
    end
    if (char_q == CW'(AD + DD + 1)) begin
      cur_ch = 8'h0D;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    // Any number of requests while busy collapse into one follow-on frame.
    if (busy && report_request) begin
      pend_d = 1'b1;
    end
    if (busy) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          char_d  = '0;
          pend_d  = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (char_q == CHAR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_START;
            char_d  = char_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_ch[bit_q];
      default: tx = 1'b1;
    endcase
  end

endmodule
